// File: rtl/dvsd_mul16_seq.sv
// 16x16 unsigned multiplier sequencer: drives one shared 8x8 combinational
// multiplier over four passes and accumulates partial products into 32 bits.
module dvsd_mul16_seq #(
  parameter int unsigned ZERO_SKIP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_p,
  output logic        busy,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_p
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_P0   = 3'd1;
  localparam logic [2:0] S_P1   = 3'd2;
  localparam logic [2:0] S_P2   = 3'd3;
  localparam logic [2:0] S_P3   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mul_ext;
  logic        zero_op;

  assign mul_ext = {16'h0000, mul_p};
  assign zero_op = (ZERO_SKIP != 0) && ((in_a == 16'h0000) || (in_b == 16'h0000));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          acc_d   = 32'h0;
          state_d = zero_op ? S_DONE : S_P0;
        end
      end
      S_P0: begin
        acc_d   = mul_ext;
        state_d = S_P1;
      end
      S_P1: begin
        acc_d   = acc_q + (mul_ext << 8);
        state_d = S_P2;
      end
      S_P2: begin
        acc_d   = acc_q + (mul_ext << 8);
        state_d = S_P3;
      end
      S_P3: begin
        acc_d   = acc_q + (mul_ext << 16);
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand byte selection per pass; the multiplier sees zeros when idle.
  always_comb begin
    mul_a = 8'h00;
    mul_b = 8'h00;
    case (state_q)
      S_P0: begin mul_a = a_q[7:0];  mul_b = b_q[7:0];  end
      S_P1: begin mul_a = a_q[15:8]; mul_b = b_q[7:0];  end
      S_P2: begin mul_a = a_q[7:0];  mul_b = b_q[15:8]; end
      S_P3: begin mul_a = a_q[15:8]; mul_b = b_q[15:8]; end
      default: begin mul_a = 8'h00; mul_b = 8'h00; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= 16'h0;
      b_q     <= 16'h0;
      acc_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_p     = acc_q;

endmodule

// File: tb/tb_dvsd_mul16_seq.sv
// Scoreboard bench for dvsd_mul16_seq with a behavioural 8x8 multiplier.
module tb_dvsd_mul16_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = 16'h0;
  logic [15:0] in_b = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_p;
  logic        busy;
  logic [7:0]  mul_a, mul_b;
  logic [15:0] mul_p;

  logic        in_valid2 = 1'b0;
  logic        in_ready2, out_valid2, busy2;
  logic        out_ready2 = 1'b1;
  logic [31:0] out_p2;
  logic [7:0]  mul_a2, mul_b2;
  logic [15:0] mul_p2;

  int checks = 0;
  int failures = 0;
  int txn = 0;
  bit rand_stall = 1'b0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  assign mul_p  = 16'(mul_a)  * 16'(mul_b);
  assign mul_p2 = 16'(mul_a2) * 16'(mul_b2);

  dvsd_mul16_seq #(.ZERO_SKIP(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .busy(busy), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p)
  );

  dvsd_mul16_seq #(.ZERO_SKIP(0)) dut_nz (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_p(out_p2), .busy(busy2), .mul_a(mul_a2), .mul_b(mul_b2), .mul_p(mul_p2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every completed output handshake is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%h expected=none", out_p);
      end else begin
        logic [31:0] exp;
        exp = sb.pop_front();
        txn++;
        $display("txn %0d out_p=%h expected=%h", txn, out_p, exp);
        chk("result", out_p, exp);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_stall) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", {31'h0, in_ready}, 32'h1);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    if (push) sb.push_back(exp);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Edges from the accepting edge (counted as 1) until out_valid is visible.
  task automatic wait_valid(output int edges);
    edges = 1;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      if (edges > 30) begin
        chk("out_valid_timeout", 32'h0, 32'h1);
        break;
      end
      @(posedge clk);
      edges++;
    end
  endtask

  logic [7:0] exp_ma[4] = '{8'h34, 8'h12, 8'h34, 8'h12};
  logic [7:0] exp_mb[4] = '{8'h78, 8'h78, 8'h56, 8'h56};

  initial begin
    int e;
    int n;
    logic [15:0] ra, rb;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_out_p", out_p, 32'h0);
    chk("rst_mul", {16'h0, mul_a, mul_b}, 32'h0);
    rst = 1'b0;

    // Pass sequence and latency on the normal path.
    issue(16'h1234, 16'h5678, 32'h06260060, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("pass_mul_a", {24'h0, mul_a}, {24'h0, exp_ma[k]});
      chk("pass_mul_b", {24'h0, mul_b}, {24'h0, exp_mb[k]});
      chk("pass_out_valid", {31'h0, out_valid}, 32'h0);
      chk("pass_busy", {31'h0, busy}, 32'h1);
      @(posedge clk);
    end
    @(negedge clk);
    chk("latency5_out_valid", {31'h0, out_valid}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_done", {31'h0, in_ready}, 32'h1);

    issue(16'h00FF, 16'h0100, 32'h0000FF00, 1'b1);
    wait_valid(e);
    chk("latency_normal", e, 32'd5);

    // Zero operand bypasses the passes.
    issue(16'h0000, 16'hABCD, 32'h0, 1'b1);
    wait_valid(e);
    chk("latency_zero_skip", e, 32'd1);
    chk("zero_skip_mul", {16'h0, mul_a, mul_b}, 32'h0);

    // Same operands on the instance without zero skip.
    @(negedge clk);
    in_a = 16'h0000;
    in_b = 16'hABCD;
    in_valid2 = 1'b1;
    @(posedge clk);
    #1 in_valid2 = 1'b0;
    n = 1;
    forever begin
      @(negedge clk);
      if (out_valid2 || n > 30) break;
      @(posedge clk);
      n++;
    end
    chk("nz_latency", n, 32'd5);
    chk("nz_result", out_p2, 32'h0);

    // Backpressure: result held, new request ignored.
    @(negedge clk);
    out_ready = 1'b0;
    issue(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1);
    wait_valid(e);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_out_p", out_p, 32'hFFFE0001);
      chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
      chk("bp_out_valid", {31'h0, out_valid}, 32'h1);
      if (i == 3) begin
        in_a = 16'h0007;
        in_b = 16'h0009;
        in_valid = 1'b1;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_released_ready", {31'h0, in_ready}, 32'h1);
    chk("bp_released_valid", {31'h0, out_valid}, 32'h0);

    // Reset during pass P2 discards the operation.
    issue(16'h1234, 16'h5678, 32'h0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_acc", out_p, 32'h0);
    chk("midrst_mul", {16'h0, mul_a, mul_b}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    issue(16'h0003, 16'h0005, 32'h0000000F, 1'b1);
    wait_valid(e);
    chk("post_rst_latency", e, 32'd5);

    // Random sweep with output stalls.
    rand_stall = 1'b1;
    for (int i = 0; i < 400; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 15) == 0) ra = 16'h0;
      if ($urandom_range(0, 15) == 0) rb = 16'h0;
      issue(ra, rb, {16'h0, ra} * {16'h0, rb}, 1'b1);
    end
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    rand_stall = 1'b0;
    #2 out_ready = 1'b1;
    chk("scoreboard_drained", sb.size(), 32'd0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
